// File: rtl/pipen_pkg.sv
// pipen_pkg: shared definitions for the elastic register pipeline.
//   occ_width(depth) : bit width of a counter spanning 0..depth inclusive.
package pipen_pkg;

  localparam int unsigned PIPEN_DEF_WIDTH = 8;
  localparam int unsigned PIPEN_DEF_DEPTH = 3;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipen_stage.sv
// pipen_stage: one valid/ready register slice of the elastic pipeline.
// Ports:
//   clk, rst          clock, async active-high reset (clears valid and data)
//   flush             synchronous clear of the valid bit
//   up_valid/up_data  incoming item from the previous slice (or pipeline input)
//   up_ready          slice can take an item this cycle (empty or draining)
//   dn_valid/dn_data  item held by this slice
//   dn_ready          next slice (or consumer) takes the held item this cycle
module pipen_stage
  import pipen_pkg::*;
#(
  parameter int unsigned WIDTH = PIPEN_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  // An empty slice always accepts, which lets items slide forward into
  // bubbles while the consumer is stalled.
  assign up_ready = !r_vld | dn_ready;
  assign dn_valid = r_vld;
  assign dn_data  = r_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (up_ready) begin
      r_vld <= up_valid;
      if (up_valid) begin
        r_dat <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipen_elastic.sv
// pipen_elastic: DEPTH-stage, WIDTH-bit register pipeline with a valid/ready
// handshake at every stage, bubble collapsing, synchronous flush and an
// occupancy count.
// Ports:
//   clk, rst             clock, async active-high reset (empties the pipeline)
//   in_data/in_valid     upstream item; in_ready = accepted this cycle
//   out_data/out_valid   item in the last stage; out_ready = consumer takes it
//   flush                synchronous clear of all stages (input refused)
//   occupancy            number of valid stages, 0..DEPTH
module pipen_elastic
  import pipen_pkg::*;
#(
  parameter int unsigned WIDTH = PIPEN_DEF_WIDTH,
  parameter int unsigned DEPTH = PIPEN_DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int unsigned OCW = occ_width(DEPTH);

  // Index i is the upstream side of stage i; index DEPTH is the output side.
  logic             w_vld [0:DEPTH];
  logic             w_rdy [0:DEPTH];
  logic [WIDTH-1:0] w_dat [0:DEPTH];

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OCW-1:0]   r_occ;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  assign w_vld[0]     = w_in_xfer;
  assign w_dat[0]     = in_data;
  assign w_rdy[DEPTH] = out_ready;

  // Ready ripples combinationally from the consumer back to the input.
  assign in_ready  = w_rdy[0] & !flush;
  assign out_valid = w_vld[DEPTH];
  assign out_data  = w_dat[DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipen_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (w_vld[g]),
      .up_data  (w_dat[g]),
      .up_ready (w_rdy[g]),
      .dn_valid (w_vld[g+1]),
      .dn_data  (w_dat[g+1]),
      .dn_ready (w_rdy[g+1])
    );
  end

  // Tracked incrementally from the boundary transfers; this equals the
  // popcount of the stage valid bits since items are only created at the
  // input and only destroyed at the output (or by flush/rst).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OCW'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_occ <= r_occ - OCW'(1);
    end
  end

  assign occupancy = r_occ;

endmodule

// File: doc/pipen_elastic.md
Name: pipen_elastic

Overview:
- Parametrised successor to the fixed 3-stage flop pipeline.
- DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake at every stage. When a consumer stalls, the pipeline compresses into empty slots (bubble collapsing).
- Adds a synchronous flush and an occupancy output.
- Sits between datapath producers and consumers that may apply backpressure.
- All stage registers update only with nonblocking assignments on the single clock edge.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); sets the minimum latency.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high; clears all stage state.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_data  output  WIDTH  data of the last stage.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- flush  input  1  synchronous clear of all stages.
- occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Stage state: per stage i (0..DEPTH-1), vld[i] and dat[i]. Stage 0 is fed by the input; stage DEPTH-1 drives the outputs.
- Reset (rst=1, asynchronous): all vld=0 and all dat=0.
  - Outputs during and after reset: out_valid=0, out_data=0, occupancy=0.
  - in_ready=1 once flush=0.
  - Reset mid-transfer drops every in-flight item with no partial output.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !vld[i] | rdy[i+1].
  - in_ready = rdy[0] & !flush.
  - Combinational path from out_ready to in_ready is accepted; depth is bounded by DEPTH.
- Stage update (posedge clk, no flush):
  - If rdy[i]=1: vld[i] <= upstream valid, and dat[i] <= upstream data when upstream valid=1. For stage 0, upstream is in_valid & in_ready.
  - If rdy[i]=0: the stage holds both vld and dat.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency and throughput:
  - With out_ready held at 1, data accepted at cycle N appears on out_data with out_valid=1 at cycle N+DEPTH.
  - Throughput is one item per cycle.
- Ordering: strictly FIFO. No item is duplicated or dropped except by flush or rst.
- Stall: out_ready=0 with out_valid=1 holds out_data stable. Upstream stages keep filling empty slots until all DEPTH stages are valid; then in_ready=0.
- Full pipeline: all vld=1 with out_ready=1 gives a simultaneous in/out transfer. in_ready=1 and occupancy is unchanged.
- Flush (synchronous, priority over everything except rst):
  - At the next edge all vld <= 0; dat is don't-care.
  - in_ready=0 during the flush cycle, so input is not accepted.
  - The current out_data may still be consumed in the flush cycle if out_ready=1; that item counts as delivered.
- Occupancy:
  - Registered sum of vld bits, updated every edge: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur. Set to 0 on flush or rst.
  - Must always equal the popcount of vld. Range is 0..DEPTH, with no wrap.
- DEPTH=1: single stage. in_ready = !vld[0] | out_ready.

Decomposition:
- Package pipen_pkg: function occ_width(depth) returning $clog2(depth+1), used for the occupancy port width.
- Sub-module pipen_stage: one valid/ready register slice with ports clk, rst, flush, up_valid, up_data, up_ready, dn_valid, dn_data, dn_ready.
- pipen_elastic instantiates DEPTH pipen_stage instances in a generate loop, plus the occupancy counter.

Test Plan:
1. Reset: assert rst mid-stream at DEPTH=3 -> out_valid=0, out_data=0, occupancy=0 immediately (no clock needed); after rst deasserts, in_ready=1.
2. Streaming: out_ready=1, drive 0x01..0x10 back-to-back -> out_data 0x01 appears 3 cycles after acceptance, then 0x02..0x10 on consecutive cycles; occupancy settles at 3.
3. Stall fill: out_ready=0, drive 0xA1,0xA2,0xA3,0xA4 -> first three accepted, in_ready=0 at occupancy=3, out_data holds 0xA1. Raise out_ready -> outputs 0xA1,0xA2,0xA3,0xA4 in order.
4. Bubble collapse: input 0x11, gap, 0x22 with out_ready=0 -> both compress into stages 2 and 1, occupancy=2; release -> 0x11 then 0x22 on consecutive cycles.
5. Flush: occupancy=3 (0xB1..0xB3), pulse flush with out_ready=1 and in_valid=1 -> 0xB1 delivered that cycle, in_ready=0. Next cycle occupancy=0 and out_valid=0; 0xB2 and 0xB3 never appear.
6. Parameter sweep: WIDTH=1/32, DEPTH=1/5 with random in_valid/out_ready -> scoreboard shows in-order, lossless delivery, and occupancy always equals the popcount of vld.
